// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg -- shared definitions for the multicycle MIPS control FSM.
//
// Contents:
//   - FSM state encoding (4 bits, exported on state_o for debug)
//   - opcode / funct field values decoded by the controller
//   - Aluctrl, EXTOp, PCSrc and AluSrcB select codes shared with the datapath
//   - ctl_t: the bundle of datapath control outputs driven per state
//   - decode_funct(): R-type funct -> ALU operation plus legality flag
// -----------------------------------------------------------------------------
package mc_pkg;

  // FSM states
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXR    = 4'd3;
  localparam logic [3:0] S_EXI    = 4'd4;
  localparam logic [3:0] S_MADDR  = 4'd5;
  localparam logic [3:0] S_MRD    = 4'd6;
  localparam logic [3:0] S_MWR    = 4'd7;
  localparam logic [3:0] S_WBR    = 4'd8;
  localparam logic [3:0] S_WBI    = 4'd9;
  localparam logic [3:0] S_WBM    = 4'd10;
  localparam logic [3:0] S_BEQ    = 4'd11;
  localparam logic [3:0] S_JMP    = 4'd12;
  localparam logic [3:0] S_ERR    = 4'd15;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;
  localparam logic [4:0] ALU_LUI = 5'd5;

  // Immediate extender modes
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  // PC source select
  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // ALU operand B select
  localparam logic [1:0] B_RD2    = 2'd0;
  localparam logic [1:0] B_FOUR   = 2'd1;
  localparam logic [1:0] B_IMM    = 2'd2;
  localparam logic [1:0] B_IMM_SH = 2'd3;

  // Datapath control bundle produced by the output decoder each cycle.
  typedef struct packed {
    logic       pcwr;
    logic [1:0] pcsrc;
    logic       irwr;
    logic       regw;
    logic       regdst;
    logic       mem2r;
    logic       memr;
    logic       memw;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [4:0] aluctrl;
    logic [1:0] extop;
    logic       done;
    logic       err;
  } ctl_t;

  typedef struct packed {
    logic       legal;
    logic [4:0] op;
  } alu_dec_t;

  // Maps an R-type funct to its ALU code; unsupported functs come back with
  // legal=0 so the FSM can trap them.
  function automatic alu_dec_t decode_funct(input logic [5:0] funct);
    alu_dec_t d;
    d.legal = 1'b1;
    d.op    = ALU_ADD;
    case (funct)
      FN_ADD:  d.op = ALU_ADD;
      FN_SUB:  d.op = ALU_SUB;
      FN_AND:  d.op = ALU_AND;
      FN_OR:   d.op = ALU_OR;
      FN_SLT:  d.op = ALU_SLT;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_wdog.sv
// -----------------------------------------------------------------------------
// mc_wdog -- data-memory wait-state watchdog.
//
// Counts consecutive cycles spent in a DM access state without mem_rdy and
// flags a timeout in the cycle the count would reach MEM_TIMEOUT. The count
// clears whenever the access completes, times out, or the FSM is elsewhere,
// so every access starts from zero.
//
// Ports:
//   clk     in  clock, rising edge
//   rst     in  asynchronous active-low reset
//   active  in  FSM is in MRD or MWR this cycle
//   rdy     in  DM access complete (mem_rdy)
//   timeout out combinational: this cycle is the MEM_TIMEOUT-th wait cycle
// -----------------------------------------------------------------------------
module mc_wdog #(
  parameter int MEM_TIMEOUT = 15   // must be >= 1
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic rdy,
  output logic timeout
);

  // The count never exceeds MEM_TIMEOUT-1 because the timeout cycle clears it.
  localparam int W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] cnt;

  // rdy has priority: a ready in the final allowed cycle is not a timeout.
  assign timeout = active && !rdy && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (active && !rdy && !timeout) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      cnt <= cnt + W'(1);
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multicycle control FSM for the MIPS datapath.
//
// Sequences PC, IM, RF, EXT, ALU and DM through IF/ID/EX/MEM/WB states,
// with a req/rdy wait handshake on DM, a DM timeout watchdog, a sticky
// error state (left only by reset) and a retired-instruction counter.
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   Op, Funct           instr[31:26], instr[5:0] from the instruction register
//   Zero                ALU zero flag (gates PCWr in BEQ)
//   mem_rdy             DM access complete; ignored outside MRD/MWR
//   PCWr, PCSrc         PC load enable / source (PC+4, branch, jump)
//   IRWr                instruction register load
//   RegW, RegDst, Mem2R RF write enable, dest select (1=rt), WD from DM
//   MemR, MemW          DM read / write request
//   AluSrcA, AluSrcB    ALU operand selects
//   Aluctrl, EXTOp      ALU operation, immediate extension mode
//   instr_done          high during the final cycle of each instruction
//   err                 high while in the error state
//   instret             retired-instruction count (wraps)
//   state_o             current FSM state, for debug
// -----------------------------------------------------------------------------
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,  // must be >= 1
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             mem_rdy,
  output logic             PCWr,
  output logic [1:0]       PCSrc,
  output logic             IRWr,
  output logic             RegW,
  output logic             RegDst,
  output logic             Mem2R,
  output logic             MemR,
  output logic             MemW,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [4:0]       Aluctrl,
  output logic [1:0]       EXTOp,
  output logic             instr_done,
  output logic             err,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  ctl_t       c;
  alu_dec_t   rdec;
  logic       mem_wait;
  logic       mem_timeout;

  assign mem_wait = (state == S_MRD) || (state == S_MWR);
  assign rdec     = decode_funct(Funct);

  mc_wdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .active (mem_wait),
    .rdy    (mem_rdy),
    .timeout(mem_timeout)
  );

  // Next-state and output decode. Outputs are a function of the state only,
  // apart from PCWr in BEQ (Zero) and retire in MWR (mem_rdy); reset forces
  // IDLE, so every output drops to 0 the moment rst falls.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // skipped one would infer a latch.
    c         = '0;
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_FETCH;

      S_FETCH: begin
        c.irwr    = 1'b1;
        c.pcwr    = 1'b1;
        c.pcsrc   = PC_SEQ;
        c.alusrcb = B_FOUR;
        c.aluctrl = ALU_ADD;
        state_nxt = S_DECODE;
      end

      S_DECODE: begin
        // PC + (sext(imm) << 2): branch target computed speculatively.
        c.alusrcb = B_IMM_SH;
        c.extop   = EXT_SIGN;
        c.aluctrl = ALU_ADD;
        case (Op)
          OP_RTYPE:                 state_nxt = S_EXR;
          OP_LW, OP_SW:             state_nxt = S_MADDR;
          OP_BEQ:                   state_nxt = S_BEQ;
          OP_J:                     state_nxt = S_JMP;
          OP_ADDI, OP_ORI, OP_LUI:  state_nxt = S_EXI;
          default:                  state_nxt = S_ERR;
        endcase
      end

      S_EXR: begin
        c.alusrca = 1'b1;
        c.alusrcb = B_RD2;
        c.aluctrl = rdec.op;
        state_nxt = rdec.legal ? S_WBR : S_ERR;
      end

      S_EXI: begin
        c.alusrca = 1'b1;
        c.alusrcb = B_IMM;
        case (Op)
          OP_ORI: begin
            c.extop   = EXT_ZERO;
            c.aluctrl = ALU_OR;
          end
          OP_LUI: begin
            // The LUI ALU code passes B through, so RD1 has no effect.
            c.extop   = EXT_LUI;
            c.aluctrl = ALU_LUI;
          end
          default: begin
            c.extop   = EXT_SIGN;
            c.aluctrl = ALU_ADD;
          end
        endcase
        state_nxt = S_WBI;
      end

      S_MADDR: begin
        c.alusrca = 1'b1;
        c.alusrcb = B_IMM;
        c.extop   = EXT_SIGN;
        c.aluctrl = ALU_ADD;
        state_nxt = (Op == OP_SW) ? S_MWR : S_MRD;
      end

      S_MRD: begin
        // Address settings stay up so the DM address is stable while waiting.
        c.alusrca = 1'b1;
        c.alusrcb = B_IMM;
        c.extop   = EXT_SIGN;
        c.aluctrl = ALU_ADD;
        c.memr    = 1'b1;
        if (mem_rdy)          state_nxt = S_WBM;
        else if (mem_timeout) state_nxt = S_ERR;
      end

      S_MWR: begin
        c.alusrca = 1'b1;
        c.alusrcb = B_IMM;
        c.extop   = EXT_SIGN;
        c.aluctrl = ALU_ADD;
        c.memw    = 1'b1;
        if (mem_rdy) begin
          c.done    = 1'b1;
          state_nxt = S_FETCH;
        end else if (mem_timeout) begin
          state_nxt = S_ERR;
        end
      end

      S_WBR: begin
        c.regw    = 1'b1;
        c.regdst  = 1'b0;
        c.done    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_WBI: begin
        c.regw    = 1'b1;
        c.regdst  = 1'b1;
        c.done    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_WBM: begin
        c.regw    = 1'b1;
        c.regdst  = 1'b1;
        c.mem2r   = 1'b1;
        c.done    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_BEQ: begin
        c.alusrca = 1'b1;
        c.alusrcb = B_RD2;
        c.aluctrl = ALU_SUB;
        c.pcsrc   = PC_BRANCH;
        c.pcwr    = Zero;
        c.done    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_JMP: begin
        c.pcwr    = 1'b1;
        c.pcsrc   = PC_JUMP;
        c.done    = 1'b1;
        state_nxt = S_FETCH;
      end

      S_ERR: c.err = 1'b1;

      // Unused encodings trap rather than wander.
      default: state_nxt = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      instret <= '0;
    end else begin
      state <= state_nxt;
      if (c.done) instret <= instret + CNT_W'(1);
    end
  end

  assign PCWr       = c.pcwr;
  assign PCSrc      = c.pcsrc;
  assign IRWr       = c.irwr;
  assign RegW       = c.regw;
  assign RegDst     = c.regdst;
  assign Mem2R      = c.mem2r;
  assign MemR       = c.memr;
  assign MemW       = c.memw;
  assign AluSrcA    = c.alusrca;
  assign AluSrcB    = c.alusrcb;
  assign Aluctrl    = c.aluctrl;
  assign EXTOp      = c.extop;
  assign instr_done = c.done;
  assign err        = c.err;
  assign state_o    = state;

endmodule
